// File: rtl/aemb2_mwb_arbiter.sv
// Two-master round-robin Wishbone arbiter sharing the RAM port (MWB) between DWB and XWB.
// Optional watchdog built when AEMB2_MWB_TIMEOUT_EN is defined.
module aemb2_mwb_arbiter #(
    parameter int         AEMB_DWB = 13,
    parameter logic [7:0] AEMB_TMO = 8'd255
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,

    input  logic [AEMB_DWB-1:2]   dwb_adr_o,
    input  logic [31:0]           dwb_dat_o,
    input  logic [3:0]            dwb_sel_o,
    input  logic                  dwb_stb_o,
    input  logic                  dwb_wre_o,
    input  logic                  dwb_cyc_o,
    input  logic                  dwb_tag_o,
    output logic [31:0]           dwb_dat_i,
    output logic                  dwb_ack_i,

    input  logic [AEMB_DWB-1:2]   xwb_adr_o,
    input  logic [31:0]           xwb_dat_o,
    input  logic [3:0]            xwb_sel_o,
    input  logic                  xwb_stb_o,
    input  logic                  xwb_wre_o,
    input  logic                  xwb_cyc_o,
    input  logic                  xwb_tag_o,
    output logic [31:0]           xwb_dat_i,
    output logic                  xwb_ack_i,

    output logic [AEMB_DWB-1:2]   mwb_adr_o,
    output logic [31:0]           mwb_dat_o,
    output logic [3:0]            mwb_sel_o,
    output logic                  mwb_stb_o,
    output logic                  mwb_wre_o,
    output logic                  mwb_cyc_o,
    output logic                  mwb_tag_o,
    input  logic [31:0]           mwb_dat_i,
    input  logic                  mwb_ack_i,

    output logic                  arb_tmo_o
);

    typedef enum logic [1:0] {IDLE, GNT_D, GNT_X} state_t;

    localparam logic LAST_D = 1'b0;
    localparam logic LAST_X = 1'b1;

    state_t      state, state_next;
    logic        last;
    logic        req_d, req_x;
    logic        arb_d, arb_x;
    logic        owner_cyc;
    logic        rearb;
    logic        tmo_fire;
    logic        ack_any;
    logic [31:0] dat_rd;

    assign req_d = dwb_cyc_o & dwb_stb_o;
    assign req_x = xwb_cyc_o & xwb_stb_o;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        owner_cyc  = 1'b0;
        state_next = state;
        arb_d      = req_d;
        arb_x      = req_x;

        unique case (state)
            GNT_D:   owner_cyc = dwb_cyc_o;
            GNT_X:   owner_cyc = xwb_cyc_o;
            default: owner_cyc = 1'b0;
        endcase

        // A watchdog expiry treats the stalled owner as if it had released the bus.
        if (tmo_fire && state == GNT_D) arb_d = 1'b0;
        if (tmo_fire && state == GNT_X) arb_x = 1'b0;

        rearb = (state == IDLE) || !owner_cyc || tmo_fire;

        if (rearb) begin
            if (arb_d && arb_x)
                state_next = (last == LAST_X) ? GNT_D : GNT_X;
            else if (arb_d)
                state_next = GNT_D;
            else if (arb_x)
                state_next = GNT_X;
            else
                state_next = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state <= IDLE;
            last  <= LAST_X;
        end else begin
            state <= state_next;
            if (rearb && state_next == GNT_D) last <= LAST_D;
            if (rearb && state_next == GNT_X) last <= LAST_X;
        end
    end

    always_comb begin
        mwb_adr_o = '0;
        mwb_dat_o = '0;
        mwb_sel_o = '0;
        mwb_stb_o = 1'b0;
        mwb_wre_o = 1'b0;
        mwb_cyc_o = 1'b0;
        mwb_tag_o = 1'b0;
        unique case (state)
            GNT_D: begin
                mwb_adr_o = dwb_adr_o;
                mwb_dat_o = dwb_dat_o;
                mwb_sel_o = dwb_sel_o;
                mwb_stb_o = dwb_stb_o;
                mwb_wre_o = dwb_wre_o;
                mwb_cyc_o = dwb_cyc_o;
                mwb_tag_o = dwb_tag_o;
            end
            GNT_X: begin
                mwb_adr_o = xwb_adr_o;
                mwb_dat_o = xwb_dat_o;
                mwb_sel_o = xwb_sel_o;
                mwb_stb_o = xwb_stb_o;
                mwb_wre_o = xwb_wre_o;
                mwb_cyc_o = xwb_cyc_o;
                mwb_tag_o = xwb_tag_o;
            end
            default: ;
        endcase
    end

`ifdef AEMB2_MWB_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       tmo_flag;

    assign tmo_fire = (state != IDLE) && (tmo_cnt == AEMB_TMO);

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            tmo_cnt  <= 8'd0;
            tmo_flag <= 1'b0;
        end else begin
            if (rearb || mwb_ack_i)
                tmo_cnt <= 8'd0;
            else if (mwb_stb_o)
                tmo_cnt <= tmo_cnt + 8'd1;
            if (tmo_fire)
                tmo_flag <= 1'b1;
        end
    end

    assign arb_tmo_o = tmo_flag;
    assign dat_rd    = tmo_fire ? 32'h0 : mwb_dat_i;
`else
    logic unused_tmo;

    assign unused_tmo = ^AEMB_TMO;
    assign tmo_fire   = 1'b0;
    assign arb_tmo_o  = 1'b0;
    assign dat_rd     = mwb_dat_i;
`endif

    assign ack_any   = mwb_ack_i | tmo_fire;
    assign dwb_ack_i = (state == GNT_D) & ack_any;
    assign xwb_ack_i = (state == GNT_X) & ack_any;
    assign dwb_dat_i = dat_rd;
    assign xwb_dat_i = dat_rd;

endmodule

// File: tb/tb_aemb2_mwb_arbiter.sv
// Directed self-checking bench for aemb2_mwb_arbiter; the watchdog section runs
// only when AEMB2_MWB_TIMEOUT_EN is defined.
module tb_aemb2_mwb_arbiter;

    localparam int AW = 13;
`ifdef AEMB2_MWB_TIMEOUT_EN
    localparam logic [7:0] TMO = 8'd4;
`else
    localparam logic [7:0] TMO = 8'd255;
`endif

    logic          sys_clk_i = 1'b0;
    logic          sys_rst_i;
    logic [AW-1:2] dwb_adr_o, xwb_adr_o, mwb_adr_o;
    logic [31:0]   dwb_dat_o, xwb_dat_o, mwb_dat_o;
    logic [3:0]    dwb_sel_o, xwb_sel_o, mwb_sel_o;
    logic          dwb_stb_o, dwb_wre_o, dwb_cyc_o, dwb_tag_o;
    logic          xwb_stb_o, xwb_wre_o, xwb_cyc_o, xwb_tag_o;
    logic [31:0]   dwb_dat_i, xwb_dat_i, mwb_dat_i;
    logic          dwb_ack_i, xwb_ack_i, mwb_ack_i;
    logic          mwb_stb_o, mwb_wre_o, mwb_cyc_o, mwb_tag_o;
    logic          arb_tmo_o;

    int pass_cnt = 0;
    int total    = 0;

    aemb2_mwb_arbiter #(.AEMB_DWB(AW), .AEMB_TMO(TMO)) dut (
        .sys_clk_i (sys_clk_i), .sys_rst_i (sys_rst_i),
        .dwb_adr_o (dwb_adr_o), .dwb_dat_o (dwb_dat_o), .dwb_sel_o (dwb_sel_o),
        .dwb_stb_o (dwb_stb_o), .dwb_wre_o (dwb_wre_o), .dwb_cyc_o (dwb_cyc_o),
        .dwb_tag_o (dwb_tag_o), .dwb_dat_i (dwb_dat_i), .dwb_ack_i (dwb_ack_i),
        .xwb_adr_o (xwb_adr_o), .xwb_dat_o (xwb_dat_o), .xwb_sel_o (xwb_sel_o),
        .xwb_stb_o (xwb_stb_o), .xwb_wre_o (xwb_wre_o), .xwb_cyc_o (xwb_cyc_o),
        .xwb_tag_o (xwb_tag_o), .xwb_dat_i (xwb_dat_i), .xwb_ack_i (xwb_ack_i),
        .mwb_adr_o (mwb_adr_o), .mwb_dat_o (mwb_dat_o), .mwb_sel_o (mwb_sel_o),
        .mwb_stb_o (mwb_stb_o), .mwb_wre_o (mwb_wre_o), .mwb_cyc_o (mwb_cyc_o),
        .mwb_tag_o (mwb_tag_o), .mwb_dat_i (mwb_dat_i), .mwb_ack_i (mwb_ack_i),
        .arb_tmo_o (arb_tmo_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge; inputs change here, outputs are sampled 1 later.
    task automatic step();
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic set_d(input logic cyc, input logic stb);
        dwb_cyc_o = cyc;
        dwb_stb_o = stb;
    endtask

    task automatic set_x(input logic cyc, input logic stb);
        xwb_cyc_o = cyc;
        xwb_stb_o = stb;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset with busy inputs: everything toward RAM and masters stays quiet.
        sys_rst_i = 1'b1;
        dwb_adr_o = 11'h5A5; dwb_dat_o = $urandom; dwb_sel_o = 4'hF;
        xwb_adr_o = 11'h3C3; xwb_dat_o = $urandom; xwb_sel_o = 4'hA;
        dwb_wre_o = 1'b1; dwb_tag_o = 1'b1; xwb_wre_o = 1'b1; xwb_tag_o = 1'b1;
        set_d(1, 1); set_x(1, 1);
        mwb_ack_i = 1'b1; mwb_dat_i = $urandom;
        step(); step(); #1;
        check("rst_ctl",  {28'h0, mwb_stb_o, mwb_wre_o, mwb_cyc_o, mwb_tag_o}, 32'h0);
        check("rst_adr",  32'(mwb_adr_o), 32'h0);
        check("rst_dat",  mwb_dat_o, 32'h0);
        check("rst_sel",  32'(mwb_sel_o), 32'h0);
        check("rst_acks", {30'h0, dwb_ack_i, xwb_ack_i}, 32'h0);
        check("rst_tmo",  32'(arb_tmo_o), 32'h0);

        set_d(0, 0); set_x(0, 0);
        dwb_wre_o = 1'b0; dwb_tag_o = 1'b0; xwb_wre_o = 1'b0; xwb_tag_o = 1'b0;
        mwb_ack_i = 1'b0;
        sys_rst_i = 1'b0;
        step(); #1;
        check("idle_after_rst", 32'(mwb_cyc_o), 32'h0);

        // Single DWB read at 0x12, RAM acks two cycles after strobe.
        step();
        dwb_adr_o = 11'h012; dwb_dat_o = 32'h1111_2222; dwb_sel_o = 4'hF;
        set_d(1, 1); #1;
        check("grant_latency_n", 32'(mwb_stb_o), 32'h0);
        step(); #1;
        check("rd_adr", 32'(mwb_adr_o), 32'h12);
        check("rd_stb", 32'(mwb_stb_o), 32'h1);
        step(); step();
        mwb_ack_i = 1'b1; mwb_dat_i = 32'hCAFE_F00D; #1;
        check("rd_acks", {30'h0, dwb_ack_i, xwb_ack_i}, 32'h2);
        check("rd_dat",  dwb_dat_i, 32'hCAFE_F00D);
        check("rd_xdat", xwb_dat_i, 32'hCAFE_F00D);
        step();
        mwb_ack_i = 1'b0; set_d(0, 0); #1;
        check("rd_ack_drop", 32'(dwb_ack_i), 32'h0);
        step(); #1;
        check("rd_idle", 32'(mwb_cyc_o), 32'h0);

        // Async reset restores last = XWB, so simultaneous requests favour DWB.
        sys_rst_i = 1'b1; #1; sys_rst_i = 1'b0;
        dwb_adr_o = 11'h100; xwb_adr_o = 11'h200;
        set_d(1, 1); set_x(1, 1);
        step(); #1;
        check("sim_d_first", 32'(mwb_adr_o), 32'h100);
        mwb_ack_i = 1'b1; #1;
        check("sim_d_ack", {30'h0, dwb_ack_i, xwb_ack_i}, 32'h2);
        step();
        mwb_ack_i = 1'b0; set_d(0, 0); #1;
        check("owner_drop_cyc", 32'(mwb_cyc_o), 32'h0);
        step(); #1;
        check("handover_adr", 32'(mwb_adr_o), 32'h200);
        check("handover_cyc", 32'(mwb_cyc_o), 32'h1);
        mwb_ack_i = 1'b1; #1;
        check("handover_ack", {30'h0, dwb_ack_i, xwb_ack_i}, 32'h1);

        // Single-beat cycles back to back: grants alternate D, X, D, X.
        for (int i = 0; i < 4; i++) begin
            step();
            mwb_ack_i = 1'b0;
            if (i % 2 == 0) begin set_x(0, 0); set_d(1, 1); end
            else            begin set_d(0, 0); set_x(1, 1); end
            step();
            set_d(1, 1); set_x(1, 1);
            mwb_ack_i = 1'b1; #1;
            check($sformatf("alt_adr_%0d", i), 32'(mwb_adr_o), (i % 2 == 0) ? 32'h100 : 32'h200);
            check($sformatf("alt_ack_%0d", i), {30'h0, dwb_ack_i, xwb_ack_i},
                  (i % 2 == 0) ? 32'h2 : 32'h1);
        end

        // Back to IDLE (last = X), then both request: D wins.
        step();
        mwb_ack_i = 1'b0; set_d(0, 0); set_x(0, 0);
        step();
        set_d(1, 1); set_x(1, 1); #1;
        check("idle_gap", 32'(mwb_cyc_o), 32'h0);
        step(); #1;
        check("rr_last_x", 32'(mwb_adr_o), 32'h100);

        // DWB holds cyc across three strobes while XWB keeps requesting.
        for (int p = 0; p < 3; p++) begin
            mwb_ack_i = 1'b1; #1;
            check($sformatf("hold_ack_%0d", p), {30'h0, dwb_ack_i, xwb_ack_i}, 32'h2);
            step();
            mwb_ack_i = 1'b0; dwb_stb_o = 1'b0; #1;
            check($sformatf("hold_gap_%0d", p), {30'h0, mwb_cyc_o, mwb_stb_o}, 32'h2);
            check($sformatf("hold_xack_%0d", p), 32'(xwb_ack_i), 32'h0);
            step();
            dwb_stb_o = 1'b1;
        end
        set_d(0, 0); #1;
        step();
        mwb_ack_i = 1'b1; #1;
        check("hold_release_adr", 32'(mwb_adr_o), 32'h200);
        check("hold_release_ack", {30'h0, dwb_ack_i, xwb_ack_i}, 32'h1);

        // Make DWB the last owner, go idle, then both request: X wins.
        step();
        mwb_ack_i = 1'b0; set_x(0, 0); set_d(1, 1);
        step(); #1;
        check("d_alone", 32'(mwb_adr_o), 32'h100);
        step();
        set_d(0, 0);
        step();
        set_d(1, 1); set_x(1, 1);
        step(); #1;
        check("rr_last_d", 32'(mwb_adr_o), 32'h200);

        // Reset in the middle of an XWB transfer abandons it without ack.
        mwb_ack_i = 1'b1;
        sys_rst_i = 1'b1; #1;
        check("midrst_acks", {30'h0, dwb_ack_i, xwb_ack_i}, 32'h0);
        check("midrst_cyc", 32'(mwb_cyc_o), 32'h0);
        sys_rst_i = 1'b0; mwb_ack_i = 1'b0;
        step(); #1;
        check("after_midrst", 32'(mwb_adr_o), 32'h100);

`ifdef AEMB2_MWB_TIMEOUT_EN
        // RAM never acks: DWB gets a zero-data ack after 4 stalled cycles, then XWB is granted.
        set_d(0, 0); set_x(0, 0);
        sys_rst_i = 1'b1; #1; sys_rst_i = 1'b0;
        mwb_dat_i = 32'hDEAD_BEEF;
        step();
        set_d(1, 1); set_x(1, 1);
        step();
        for (int s = 0; s < 4; s++) begin
            #1;
            check($sformatf("tmo_stall_%0d", s), 32'(dwb_ack_i), 32'h0);
            step();
        end
        #1;
        check("tmo_ack", {30'h0, dwb_ack_i, xwb_ack_i}, 32'h2);
        check("tmo_dat", dwb_dat_i, 32'h0);
        step(); #1;
        check("tmo_flag", 32'(arb_tmo_o), 32'h1);
        check("tmo_next_owner", 32'(mwb_adr_o), 32'h200);
`else
        check("tmo_tied_low", 32'(arb_tmo_o), 32'h0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
